// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge return path.
// Holds the per-tag completion state encoding, the default widths of a completion
// table entry, the AXI response encodings and the round-robin pointer encoding.
package apb2axi_pkg;

  localparam int CPL_DATA_W = 64;  // read data stored per tag
  localparam int CPL_BEAT_W = 8;   // saturating read beat counter

  // AXI BRESP/RRESP encodings; numerically larger means worse.
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    CPL_IDLE  = 2'd0,
    CPL_ACCUM = 2'd1,
    CPL_DONE  = 2'd2
  } cpl_state_e;

  // Completion table entry at the default widths.
  typedef struct packed {
    cpl_state_e              state;
    logic                    is_write;
    logic [1:0]              resp;
    logic [CPL_BEAT_W-1:0]   beats;
    logic [CPL_DATA_W-1:0]   data;
  } cpl_entry_t;

  // Which requester holds priority on the next contested cycle.
  typedef enum logic {
    RR_WR = 1'b0,
    RR_RD = 1'b1
  } rr_sel_e;

  // Worst-of-two AXI responses.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apb2axi_rr_arb2.sv
// Two-requester round-robin arbiter (write responses vs read beats).
// A lone request is always granted. When both request, the pointer decides and then
// moves to the loser so the next contested cycle favours the other side.
// Ports:
//   aclk, areset        clock, synchronous active-high reset (grants forced low)
//   req_wr, req_rd      requests (FIFO not empty)
//   grant_wr, grant_rd  one-hot-or-zero grants, combinational
module apb2axi_rr_arb2
  import apb2axi_pkg::*;
(
  input  logic aclk,
  input  logic areset,
  input  logic req_wr,
  input  logic req_rd,
  output logic grant_wr,
  output logic grant_rd
);

  rr_sel_e ptr;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (!areset) begin
      if (req_wr && req_rd) begin
        grant_wr = (ptr == RR_WR);
        grant_rd = (ptr == RR_RD);
      end else begin
        grant_wr = req_wr;
        grant_rd = req_rd;
      end
    end
  end

  always_ff @(posedge aclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    if (areset) begin
      ptr <= RR_WR;
    end else if (req_wr && req_rd) begin
      ptr <= grant_wr ? RR_RD : RR_WR;
    end
  end

endmodule

// File: rtl/apb2axi_rsp_mgr.sv
// Return-path response manager. Drains the AXI write-response and read-data FIFOs
// (at most one pop per cycle, round-robin when both are non-empty) and records each
// completion in a per-tag table. The APB gateway reads the table combinationally by
// tag and frees a DONE entry with cpl_ack.
// Ports:
//   aclk, areset                 clock, synchronous active-high reset
//   wr_rsp_*                     B-response FIFO head (valid/ready/tag/resp)
//   rd_rsp_*                     R-beat FIFO head (valid/ready/tag/data/resp/last)
//   cpl_qry_tag -> cpl_done, cpl_is_write, cpl_resp, cpl_data, cpl_beats   table query
//   cpl_ack, cpl_ack_tag         free a DONE tag
//   cpl_evt_valid, cpl_evt_tag   pulse when a tag enters DONE
//   dup_err                      pulse when a response to a DONE tag was dropped
module apb2axi_rsp_mgr
  import apb2axi_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int DATA_W = CPL_DATA_W,
  parameter int BEAT_W = CPL_BEAT_W
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              wr_rsp_valid,
  output logic              wr_rsp_ready,
  input  logic [TAG_W-1:0]  wr_rsp_tag,
  input  logic [1:0]        wr_rsp_resp,
  input  logic              rd_rsp_valid,
  output logic              rd_rsp_ready,
  input  logic [TAG_W-1:0]  rd_rsp_tag,
  input  logic [DATA_W-1:0] rd_rsp_data,
  input  logic [1:0]        rd_rsp_resp,
  input  logic              rd_rsp_last,
  input  logic [TAG_W-1:0]  cpl_qry_tag,
  output logic              cpl_done,
  output logic              cpl_is_write,
  output logic [1:0]        cpl_resp,
  output logic [DATA_W-1:0] cpl_data,
  output logic [BEAT_W-1:0] cpl_beats,
  input  logic              cpl_ack,
  input  logic [TAG_W-1:0]  cpl_ack_tag,
  output logic              cpl_evt_valid,
  output logic [TAG_W-1:0]  cpl_evt_tag,
  output logic              dup_err
);

  localparam int NUM_TAGS = 2 ** TAG_W;

  // Entry layout at this instance's widths (same fields as cpl_entry_t).
  typedef struct packed {
    cpl_state_e          state;
    logic                is_write;
    logic [1:0]          resp;
    logic [BEAT_W-1:0]   beats;
    logic [DATA_W-1:0]   data;
  } entry_t;

  entry_t tbl [NUM_TAGS];

  logic             grant_wr, grant_rd;
  logic             acc_valid, acc_upd, acc_dup, ack_clr;
  logic [TAG_W-1:0] acc_tag;
  entry_t           base, nxt;

  apb2axi_rr_arb2 u_arb (
    .aclk     (aclk),
    .areset   (areset),
    .req_wr   (wr_rsp_valid),
    .req_rd   (rd_rsp_valid),
    .grant_wr (grant_wr),
    .grant_rd (grant_rd)
  );

  // Select the accepted response and the entry it lands on. An ack to the same tag
  // in the same cycle is applied first, so the accept rebuilds the entry from IDLE.
  always_comb begin
    acc_valid = grant_wr | grant_rd;
    acc_tag   = grant_wr ? wr_rsp_tag : rd_rsp_tag;
    ack_clr   = cpl_ack && (tbl[cpl_ack_tag].state == CPL_DONE);
    base      = (ack_clr && (cpl_ack_tag == acc_tag)) ? '0 : tbl[acc_tag];
    acc_dup   = acc_valid && (base.state == CPL_DONE);
    acc_upd   = acc_valid && (base.state != CPL_DONE);
  end

  // Next state/contents of the accepted entry.
  always_comb begin
    nxt = base;
    if (grant_wr) begin
      nxt.state    = CPL_DONE;
      nxt.is_write = 1'b1;
      nxt.resp     = wr_rsp_resp;
      nxt.beats    = '0;
    end else begin
      nxt.is_write = 1'b0;
      nxt.data     = rd_rsp_data;
      if (base.state == CPL_IDLE) begin
        nxt.beats = BEAT_W'(1);
        nxt.resp  = rd_rsp_resp;
      end else begin
        nxt.beats = (base.beats == '1) ? base.beats : base.beats + BEAT_W'(1);
        nxt.resp  = resp_worst(base.resp, rd_rsp_resp);
      end
      nxt.state = rd_rsp_last ? CPL_DONE : CPL_ACCUM;
    end
  end

  // Table and event registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      // NOTE: the table is reset (not left to power-up values) because queries must
      // read every tag as IDLE with zero fields straight after reset.
      for (int i = 0; i < NUM_TAGS; i++) begin
        tbl[i] <= '0;
      end
      cpl_evt_valid <= 1'b0;
      cpl_evt_tag   <= '0;
      dup_err       <= 1'b0;
    end else begin
      // The accept write comes after the clear, so on a shared tag it wins.
      if (ack_clr) begin
        tbl[cpl_ack_tag] <= '0;
      end
      if (acc_upd) begin
        tbl[acc_tag] <= nxt;
      end
      cpl_evt_valid <= acc_upd && (nxt.state == CPL_DONE);
      if (acc_upd && (nxt.state == CPL_DONE)) begin
        cpl_evt_tag <= acc_tag;
      end
      dup_err <= acc_dup;
    end
  end

  // Pops and query outputs.
  always_comb begin
    wr_rsp_ready = grant_wr;
    rd_rsp_ready = grant_rd;
    cpl_done     = (tbl[cpl_qry_tag].state == CPL_DONE);
    cpl_is_write = tbl[cpl_qry_tag].is_write;
    cpl_resp     = tbl[cpl_qry_tag].resp;
    cpl_data     = tbl[cpl_qry_tag].data;
    cpl_beats    = tbl[cpl_qry_tag].beats;
  end

endmodule
